// File: rtl/apu_wb_scheduler_pkg.sv
// Shared APU core definitions: op class encodings and the default
// per-class pipeline latency vector used by the writeback scheduler.
package apu_wb_scheduler_pkg;

    // Op class encodings as seen on the issue interface
    typedef enum logic [2:0] {
        APU_ADDSUB = 3'd0,
        APU_MULT   = 3'd1,
        APU_CAST   = 3'd2,
        APU_MAC    = 3'd3,
        APU_DIV    = 3'd4,
        APU_SQRT   = 3'd5
    } apu_class_e;

    localparam int APU_NUM_CLASSES = 6;
    localparam int APU_MAX_LAT     = 5;
    localparam int APU_LAT_W       = $clog2(APU_MAX_LAT + 1);

    // Class i latency sits at [i*APU_LAT_W +: APU_LAT_W]; class 0 is the LSB field.
    // SQRT=5, DIV=4, MAC=2, CAST=1, MULT=1, ADDSUB=1.
    localparam logic [APU_NUM_CLASSES*APU_LAT_W-1:0] APU_CLASS_LAT =
        {3'd5, 3'd4, 3'd2, 3'd1, 3'd1, 3'd1};

endpackage

// File: rtl/apu_wb_scheduler_tag.sv
// Compares one register tag against every reservation slot and returns
// a per-slot hit vector (bit k-1 corresponds to slot k).
module apu_tag_match #(
    parameter int MAX_LAT = 5,
    parameter int TAG_W   = 6
) (
    input  logic [TAG_W-1:0]         tag_i,
    input  logic [MAX_LAT-1:0]       valid_i,
    input  logic [MAX_LAT*TAG_W-1:0] rd_i,
    output logic [MAX_LAT-1:0]       hit_o
);

    // A slot hits when it holds a live reservation whose rd equals the tag
    always_comb begin
        hit_o = '0;
        for (int k = 0; k < MAX_LAT; k++) begin
            hit_o[k] = valid_i[k] && (rd_i[k*TAG_W +: TAG_W] == tag_i);
        end
    end

endmodule

// File: rtl/apu_wb_scheduler.sv
// Issue-side scheduler for the shared APU path. Keeps a shift table of
// writeback reservations, one slot per future cycle, and only accepts an
// op whose writeback slot is free and which cannot overtake an older write
// to the same destination. Also reports in-flight rd hazards for sources.
module apu_wb_scheduler
    import apu_wb_scheduler_pkg::*;
#(
    parameter int NUM_CLASSES = APU_NUM_CLASSES,
    parameter int MAX_LAT     = APU_MAX_LAT,
    parameter int TAG_W       = 6,
    parameter int NUM_RS      = 3,
    parameter logic [NUM_CLASSES*$clog2(MAX_LAT+1)-1:0] CLASS_LAT = APU_CLASS_LAT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              issue_valid_i,
    input  logic [$clog2(NUM_CLASSES)-1:0]    issue_class_i,
    input  logic [TAG_W-1:0]                  issue_rd_i,
    output logic                              issue_ready_o,
    input  logic                              kill_i,
    input  logic [NUM_RS*TAG_W-1:0]           chk_rs_i,
    output logic [NUM_RS-1:0]                 chk_hazard_o,
    output logic                              wb_valid_o,
    output logic [TAG_W-1:0]                  wb_rd_o,
    output logic                              busy_o,
    output logic [$clog2(MAX_LAT+1)-1:0]      occupancy_o
);

    localparam int LAT_W   = $clog2(MAX_LAT + 1);
    localparam int CLASS_W = $clog2(NUM_CLASSES);

    // Every class latency has to fit in the table and be at least one cycle
    for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_lat_chk
        if (int'(CLASS_LAT[i*LAT_W +: LAT_W]) < 1 ||
            int'(CLASS_LAT[i*LAT_W +: LAT_W]) > MAX_LAT) begin : g_bad_lat
            $error("apu_wb_scheduler: class latency out of range 1..MAX_LAT");
        end
    end

    // Slot k (1-based) lives at bit k-1; slot 1 writes back this cycle.
    // Invalid slots always carry rd=0, so wb_rd_o reads 0 when idle.
    logic [MAX_LAT-1:0]       valid_q, valid_d;
    logic [MAX_LAT*TAG_W-1:0] rd_q, rd_d;

    logic [LAT_W-1:0]   lat;
    logic               class_ok;
    logic               port_free;
    logic               waw_clear;
    logic               accept;
    logic [MAX_LAT-1:0] waw_hit;
    logic [LAT_W-1:0]   occ;

    // Look up the latency of the requested class and reject unknown encodings
    always_comb begin
        lat      = '0;
        class_ok = ({1'b0, issue_class_i} < (CLASS_W+1)'(NUM_CLASSES));
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if ({1'b0, issue_class_i} == (CLASS_W+1)'(i)) begin
                lat = CLASS_LAT[i*LAT_W +: LAT_W];
            end
        end
    end

    apu_tag_match #(
        .MAX_LAT (MAX_LAT),
        .TAG_W   (TAG_W)
    ) u_waw_match (
        .tag_i   (issue_rd_i),
        .valid_i (valid_q),
        .rd_i    (rd_q),
        .hit_o   (waw_hit)
    );

    // Writeback-port collision looks at slot L+1 (which shifts into slot L);
    // WAW ordering forbids any same-rd reservation landing later than slot L+1
    always_comb begin
        port_free = 1'b1;
        waw_clear = 1'b1;
        for (int k = 1; k <= MAX_LAT; k++) begin
            if (k == int'(lat) + 1 && valid_q[k-1]) begin
                port_free = 1'b0;
            end
            if (k > int'(lat) + 1 && waw_hit[k-1]) begin
                waw_clear = 1'b0;
            end
        end
        accept = issue_valid_i && class_ok && !kill_i && port_free && waw_clear;
    end

    assign issue_ready_o = accept;

    // Advance the table by one slot, insert the accepted op, or flush on kill
    always_comb begin
        valid_d = valid_q >> 1;
        rd_d    = rd_q >> TAG_W;
        if (kill_i) begin
            valid_d = '0;
            rd_d    = '0;
        end else begin
            for (int k = 0; k < MAX_LAT; k++) begin
                if (accept && k == int'(lat) - 1) begin
                    valid_d[k]               = 1'b1;
                    rd_d[k*TAG_W +: TAG_W]   = issue_rd_i;
                end
            end
        end
    end

    // Reservation table register; reset drops every pending writeback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
        end
    end

    // Source hazard ports: any live reservation writing that tag is a hazard
    for (genvar i = 0; i < NUM_RS; i++) begin : g_rs
        logic [MAX_LAT-1:0] hit;

        apu_tag_match #(
            .MAX_LAT (MAX_LAT),
            .TAG_W   (TAG_W)
        ) u_rs_match (
            .tag_i   (chk_rs_i[i*TAG_W +: TAG_W]),
            .valid_i (valid_q),
            .rd_i    (rd_q),
            .hit_o   (hit)
        );

        assign chk_hazard_o[i] = |hit;
    end

    // Count live reservations for occupancy and busy reporting
    always_comb begin
        occ = '0;
        for (int k = 0; k < MAX_LAT; k++) begin
            if (valid_q[k]) begin
                occ = occ + LAT_W'(1);
            end
        end
    end

    assign occupancy_o = occ;
    assign busy_o      = (occ != '0);
    assign wb_valid_o  = valid_q[0];
    assign wb_rd_o     = rd_q[TAG_W-1:0];

endmodule

// File: tb/tb_apu_wb_scheduler.sv
// Self-checking bench for apu_wb_scheduler: a table of per-cycle issue
// vectors with expected ready, a writeback scoreboard filled on each
// expected acceptance, and a hand-written mid-operation reset sequence.
module tb_apu_wb_scheduler;
    import apu_wb_scheduler_pkg::*;

    typedef struct {
        logic       valid;
        logic [2:0] cls;
        logic [5:0] rd;
        logic       kill;
        logic       rst_pulse;
        logic       exp_ready;
    } vec_t;

    typedef struct {
        int         due;
        logic [5:0] rd;
    } sb_t;

    logic        clk;
    logic        rst;
    logic        issue_valid_i;
    logic [2:0]  issue_class_i;
    logic [5:0]  issue_rd_i;
    logic        issue_ready_o;
    logic        kill_i;
    logic [17:0] chk_rs_i;
    logic [2:0]  chk_hazard_o;
    logic        wb_valid_o;
    logic [5:0]  wb_rd_o;
    logic        busy_o;
    logic [2:0]  occupancy_o;

    vec_t vecs[$];
    sb_t  sb[$];
    int   lat_tbl [0:7] = '{1, 1, 1, 2, 4, 5, 0, 0};
    int   cyc;
    int   tests;
    int   fails;

    apu_wb_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid_i (issue_valid_i),
        .issue_class_i (issue_class_i),
        .issue_rd_i    (issue_rd_i),
        .issue_ready_o (issue_ready_o),
        .kill_i        (kill_i),
        .chk_rs_i      (chk_rs_i),
        .chk_hazard_o  (chk_hazard_o),
        .wb_valid_o    (wb_valid_o),
        .wb_rd_o       (wb_rd_o),
        .busy_o        (busy_o),
        .occupancy_o   (occupancy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic [2:0] c, input logic [5:0] r,
                                input logic k, input logic rp, input logic er);
        vec_t t;
        t.valid = v; t.cls = c; t.rd = r; t.kill = k; t.rst_pulse = rp; t.exp_ready = er;
        return t;
    endfunction

    task automatic addVec(input logic v, input logic [2:0] c, input logic [5:0] r,
                          input logic k, input logic er);
        vecs.push_back(mk(v, c, r, k, 1'b0, er));
    endtask

    task automatic addIdle(input logic [5:0] r, input int n);
        for (int i = 0; i < n; i++) vecs.push_back(mk(1'b0, 3'd0, r, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        checkOutput("rst_wb_rd", 32'(wb_rd_o), 32'd0);
        checkOutput("rst_hazard", 32'(chk_hazard_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_occupancy", 32'(occupancy_o), 32'd0);
    endtask

    task automatic checkCycle(input vec_t v);
        logic       exp_wb;
        logic [5:0] exp_rd;
        logic [2:0] exp_haz;
        logic [5:0] rs [3];
        exp_wb = 1'b0;
        exp_rd = '0;
        exp_haz = '0;
        rs[0] = v.rd; rs[1] = 6'd5; rs[2] = 6'd7;
        foreach (sb[j]) begin
            if (sb[j].due == cyc) begin
                exp_wb = 1'b1;
                exp_rd = sb[j].rd;
            end
            for (int i = 0; i < 3; i++) if (sb[j].rd == rs[i]) exp_haz[i] = 1'b1;
        end
        checkOutput("issue_ready", 32'(issue_ready_o), 32'(v.exp_ready));
        checkOutput("wb_valid", 32'(wb_valid_o), 32'(exp_wb));
        if (exp_wb) checkOutput("wb_rd", 32'(wb_rd_o), 32'(exp_rd));
        checkOutput("occupancy", 32'(occupancy_o), 32'(sb.size()));
        checkOutput("busy", 32'(busy_o), 32'(sb.size() != 0));
        checkOutput("hazard", 32'(chk_hazard_o), 32'(exp_haz));
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (sb[j].due <= cyc) sb.delete(j);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        sb_t e;
        issue_valid_i = v.valid;
        issue_class_i = v.cls;
        issue_rd_i    = v.rd;
        kill_i        = v.kill;
        chk_rs_i      = {6'd7, 6'd5, v.rd};
        if (v.rst_pulse) begin
            #1 rst = 1'b1;
            #1 checkReset();
            sb.delete();
            #1 rst = 1'b0;
            #1;
        end else begin
            #4;
        end
        checkCycle(v);
        if (v.kill) begin
            sb.delete();
        end else if (v.exp_ready) begin
            e.due = cyc + lat_tbl[v.cls];
            e.rd  = v.rd;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc = 0;
        rst = 1'b1;
        issue_valid_i = 1'b0;
        issue_class_i = '0;
        issue_rd_i = '0;
        kill_i = 1'b0;
        chk_rs_i = '0;

        // Single DIV: writeback rd5 in cycle 4, hazard cycles 1..4
        addVec(1'b1, APU_DIV, 6'd5, 1'b0, 1'b1);
        addIdle(6'd5, 5);
        // Port collision: SQRT rd1 then DIV rd2 stalls one cycle
        addVec(1'b1, APU_SQRT, 6'd1, 1'b0, 1'b1);
        addVec(1'b1, APU_DIV, 6'd2, 1'b0, 1'b0);
        addVec(1'b1, APU_DIV, 6'd2, 1'b0, 1'b1);
        addIdle(6'd1, 5);
        // WAW: ADDSUB rd7 waits until the DIV rd7 reaches slot 1
        addVec(1'b1, APU_DIV, 6'd7, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) addVec(1'b1, APU_ADDSUB, 6'd7, 1'b0, 1'b0);
        addVec(1'b1, APU_ADDSUB, 6'd7, 1'b0, 1'b1);
        addIdle(6'd7, 2);
        // Back-to-back ADDSUB
        for (int i = 0; i < 10; i++) addVec(1'b1, APU_ADDSUB, 6'(i), 1'b0, 1'b1);
        addIdle(6'd0, 2);
        // Kill with a concurrent MULT request
        addVec(1'b1, APU_DIV, 6'd3, 1'b0, 1'b1);
        addIdle(6'd3, 1);
        addVec(1'b1, APU_MULT, 6'd4, 1'b1, 1'b0);
        addIdle(6'd3, 3);
        // Non-decreasing latencies issue every cycle
        addVec(1'b1, APU_ADDSUB, 6'd10, 1'b0, 1'b1);
        addVec(1'b1, APU_MAC, 6'd11, 1'b0, 1'b1);
        addVec(1'b1, APU_DIV, 6'd12, 1'b0, 1'b1);
        addVec(1'b1, APU_SQRT, 6'd13, 1'b0, 1'b1);
        addIdle(6'd13, 6);
        // Fill every slot with SQRT ops
        for (int i = 0; i < 5; i++) addVec(1'b1, APU_SQRT, 6'(20 + i), 1'b0, 1'b1);
        addIdle(6'd20, 6);
        // Out-of-range classes and kill with an empty table
        addVec(1'b1, 3'd6, 6'd30, 1'b0, 1'b0);
        addVec(1'b1, 3'd7, 6'd30, 1'b0, 1'b0);
        addVec(1'b1, APU_ADDSUB, 6'd30, 1'b1, 1'b0);
        addVec(1'b1, APU_ADDSUB, 6'd30, 1'b0, 1'b1);
        addIdle(6'd30, 2);

        repeat (2) @(posedge clk);
        #1;
        checkReset();
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

        // Reset mid-operation: SQRT rd9 is lost, no writeback afterwards
        applyStimulus(mk(1'b1, APU_SQRT, 6'd9, 1'b0, 1'b0, 1'b1));
        applyStimulus(mk(1'b0, 3'd0, 6'd9, 1'b0, 1'b0, 1'b0));
        applyStimulus(mk(1'b0, 3'd0, 6'd9, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 4; i++) applyStimulus(mk(1'b0, 3'd0, 6'd9, 1'b0, 1'b0, 1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
